// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
// Hazard sequencer for a 5-stage MIPS pipe. It sits beside decode and drives the
// PC, IF/ID and ID/EX enables, the flushes and the ID/EX bubble.
//   - Load-use stall: one cycle, for the instruction held in IF/ID.
//   - Branch flush: FLUSH_CYC cycles after a branch taken in MEM.
//   - Memory freeze: the whole pipe holds while data memory is busy.
// Optional feature macro: PIPE_PERF_CNT_EN adds saturating stall and flush counters.
//
// Interface note: there is no valid/ready handshake. Every input is sampled on each
// rising edge. Every output is a function of the registered state and the current inputs.
//
// Flush counter meaning: flush_cnt_q holds the number of flush cycles still owed,
// including the current cycle. This holds in FLUSH and in FREEZE. A branch frozen
// in RUN therefore owes FLUSH_CYC cycles. A freeze entered from FLUSH keeps its
// remaining count. The cycle that leaves FREEZE is the first of the owed cycles.
module pipeline_hazard_ctrl #(
  parameter int FLUSH_CYC = 3,
  parameter int CNT_W     = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_data_Instr,
  input  logic        i_con_ex_memread,
  input  logic [4:0]  i_addr_ex_rt,
  input  logic        i_con_mem_branch_tk,
  input  logic        i_con_mem_busy,
  output logic        o_con_pc_we,
  output logic        o_con_ifid_we,
  output logic        o_con_ifid_flush,
  output logic        o_con_idex_bubble,
  output logic        o_con_exmem_flush,
  output logic [1:0]  o_con_state
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] o_data_stall_cnt,
  output logic [CNT_W-1:0] o_data_flush_cnt
`endif
);

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_FLUSH  = 2'd1;
  localparam logic [1:0] ST_FREEZE = 2'd2;

  localparam logic [2:0] CNT_FULL   = 3'(FLUSH_CYC);
  localparam logic [2:0] CNT_RELOAD = 3'(FLUSH_CYC - 1);

  logic [1:0] state_q, state_d;
  logic [2:0] flush_cnt_q, flush_cnt_d;
  logic       pend_br_q, pend_br_d;
  logic       lu_hit;
  logic       unused_instr_bits;

  // Only the rs and rt fields of the instruction take part in hazard detection.
  assign unused_instr_bits = ^{i_data_Instr[31:26], i_data_Instr[15:0]};

  assign lu_hit = i_con_ex_memread && (i_addr_ex_rt != 5'd0) &&
                  ((i_addr_ex_rt == i_data_Instr[25:21]) ||
                   (i_addr_ex_rt == i_data_Instr[20:16]));

  // State register: FSM state, owed flush count and pending-branch flag.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_RUN;
      flush_cnt_q <= 3'd0;
      pend_br_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      pend_br_q   <= pend_br_d;
    end
  end

  // Next-state logic. Priority is busy, then branch/flush, then load-use.
  // Encoding 3 is not used and falls back to RUN.
  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    pend_br_d   = pend_br_q;
    if (i_con_mem_busy) begin
      state_d = ST_FREEZE;
      if (i_con_mem_branch_tk) begin
        pend_br_d   = 1'b1;
        flush_cnt_d = CNT_FULL;
      end else if (state_q == ST_FLUSH) begin
        pend_br_d = 1'b1;
      end
    end else if (i_con_mem_branch_tk) begin
      // A fresh branch: this cycle flushes, and FLUSH covers the rest.
      pend_br_d   = 1'b0;
      flush_cnt_d = CNT_RELOAD;
      state_d     = (CNT_RELOAD != 3'd0) ? ST_FLUSH : ST_RUN;
    end else if (state_q == ST_FLUSH) begin
      if (flush_cnt_q <= 3'd1) begin
        flush_cnt_d = 3'd0;
        state_d     = ST_RUN;
      end else begin
        flush_cnt_d = flush_cnt_q - 3'd1;
      end
    end else if (state_q == ST_FREEZE) begin
      pend_br_d = 1'b0;
      if (pend_br_q && (flush_cnt_q > 3'd1)) begin
        flush_cnt_d = flush_cnt_q - 3'd1;
        state_d     = ST_FLUSH;
      end else begin
        flush_cnt_d = 3'd0;
        state_d     = ST_RUN;
      end
    end else begin
      state_d = ST_RUN;
    end
  end

  // Output logic: combinational from the registered state and the current inputs.
  always_comb begin
    o_con_pc_we       = 1'b1;
    o_con_ifid_we     = 1'b1;
    o_con_ifid_flush  = 1'b0;
    o_con_idex_bubble = 1'b0;
    o_con_exmem_flush = 1'b0;
    o_con_state       = state_q;
    if (i_rst) begin
      o_con_pc_we       = 1'b0;
      o_con_ifid_we     = 1'b0;
      o_con_ifid_flush  = 1'b1;
      o_con_idex_bubble = 1'b1;
      o_con_exmem_flush = 1'b1;
      o_con_state       = ST_RUN;
    end else if (i_con_mem_busy) begin
      o_con_pc_we   = 1'b0;
      o_con_ifid_we = 1'b0;
    end else if (i_con_mem_branch_tk || (state_q == ST_FLUSH) ||
                 ((state_q == ST_FREEZE) && pend_br_q)) begin
      o_con_ifid_flush  = 1'b1;
      o_con_idex_bubble = 1'b1;
      o_con_exmem_flush = 1'b1;
    end else if (lu_hit) begin
      o_con_pc_we       = 1'b0;
      o_con_ifid_we     = 1'b0;
      o_con_idex_bubble = 1'b1;
    end
  end

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_perf_q, flush_perf_d;

  // Saturating event counters. Cycles spent in reset are not counted.
  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    flush_perf_d = flush_perf_q;
    if (!i_rst && !o_con_pc_we && (stall_cnt_q != {CNT_W{1'b1}}))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (!i_rst && o_con_ifid_flush && (flush_perf_q != {CNT_W{1'b1}}))
      flush_perf_d = flush_perf_q + CNT_W'(1);
  end

  // Counter registers, cleared by reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      stall_cnt_q  <= '0;
      flush_perf_q <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      flush_perf_q <= flush_perf_d;
    end
  end

  assign o_data_stall_cnt = stall_cnt_q;
  assign o_data_flush_cnt = flush_perf_q;
`else
  localparam int unused_cnt_w = CNT_W;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl (FLUSH_CYC=3, CNT_W=4).
// The expected output vector is {pc_we, ifid_we, ifid_flush, idex_bubble, exmem_flush, state[1:0]}.
module tb_pipeline_hazard_ctrl;

  localparam logic [6:0] E_RST   = 7'b0011100;
  localparam logic [6:0] E_RUN   = 7'b1100000;
  localparam logic [6:0] E_STL   = 7'b0001000;
  localparam logic [6:0] E_BR    = 7'b1111100;
  localparam logic [6:0] E_FL    = 7'b1111101;
  localparam logic [6:0] E_HOLDR = 7'b0000000;
  localparam logic [6:0] E_HOLDF = 7'b0000001;
  localparam logic [6:0] E_FRZ   = 7'b0000010;
  localparam logic [6:0] E_FRX   = 7'b1111110;
  localparam logic [6:0] E_FRRUN = 7'b1100010;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [31:0] i_data_Instr;
  logic        i_con_ex_memread;
  logic [4:0]  i_addr_ex_rt;
  logic        i_con_mem_branch_tk;
  logic        i_con_mem_busy;
  logic        o_con_pc_we, o_con_ifid_we, o_con_ifid_flush;
  logic        o_con_idex_bubble, o_con_exmem_flush;
  logic [1:0]  o_con_state;
`ifdef PIPE_PERF_CNT_EN
  logic [3:0]  o_data_stall_cnt, o_data_flush_cnt;
  int          mdl_stall = 0;
  int          mdl_flush = 0;
`endif

  logic [6:0] exp_q[$];
  string      tag_q[$];
  int         n_checks = 0;
  int         n_pass = 0;

  pipeline_hazard_ctrl #(.FLUSH_CYC(3), .CNT_W(4)) dut (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .i_data_Instr(i_data_Instr),
    .i_con_ex_memread(i_con_ex_memread),
    .i_addr_ex_rt(i_addr_ex_rt),
    .i_con_mem_branch_tk(i_con_mem_branch_tk),
    .i_con_mem_busy(i_con_mem_busy),
    .o_con_pc_we(o_con_pc_we),
    .o_con_ifid_we(o_con_ifid_we),
    .o_con_ifid_flush(o_con_ifid_flush),
    .o_con_idex_bubble(o_con_idex_bubble),
    .o_con_exmem_flush(o_con_exmem_flush),
    .o_con_state(o_con_state)
`ifdef PIPE_PERF_CNT_EN
    ,
    .o_data_stall_cnt(o_data_stall_cnt),
    .o_data_flush_cnt(o_data_flush_cnt)
`endif
  );

  // Clock generation.
  always #5 i_clk = ~i_clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] mk_instr(input logic [4:0] rs, input logic [4:0] rt);
    return {6'h23, rs, rt, 16'h0010};
  endfunction

  // Driver: applies one cycle of stimulus just after the edge and queues its expectation.
  task automatic drive(input string tag, input logic rst, input logic [4:0] rs,
                       input logic [4:0] rtf, input logic mr, input logic [4:0] ex_rt,
                       input logic br, input logic busy, input logic [6:0] exp);
    @(posedge i_clk);
    #1;
    i_rst               = rst;
    i_data_Instr        = mk_instr(rs, rtf);
    i_con_ex_memread    = mr;
    i_addr_ex_rt        = ex_rt;
    i_con_mem_branch_tk = br;
    i_con_mem_busy      = busy;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
  endtask

  task automatic idle(input string tag, input logic [6:0] exp);
    drive(tag, 1'b0, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, exp);
  endtask

  // Scoreboard: compares the outputs at the falling edge against the oldest expectation.
  always @(negedge i_clk) begin
    if (exp_q.size() > 0) begin
      logic [6:0] e;
      string      t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check_eq(t, {25'd0, o_con_pc_we, o_con_ifid_we, o_con_ifid_flush,
                   o_con_idex_bubble, o_con_exmem_flush, o_con_state}, {25'd0, e});
`ifdef PIPE_PERF_CNT_EN
      if (e == E_RST) begin
        mdl_stall = 0;
        mdl_flush = 0;
      end else begin
        if (!e[6] && mdl_stall < 15) mdl_stall++;
        if (e[4] && mdl_flush < 15) mdl_flush++;
      end
`endif
    end
  end

  // Stimulus sequence.
  initial begin
    logic [4:0] rt, rs, rtf;
    logic       mr, hit;
    i_rst = 1'b1; i_data_Instr = 32'd0; i_con_ex_memread = 1'b0;
    i_addr_ex_rt = 5'd0; i_con_mem_branch_tk = 1'b0; i_con_mem_busy = 1'b0;

    // Reset held two cycles, then released.
    drive("rst0", 1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, E_RST);
    drive("rst1", 1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, E_RST);
    idle("run_after_rst", E_RUN);

    // Load-use on rs, on rt, and with ex_rt of zero.
    drive("lu_rs", 1'b0, 5'd5, 5'd9, 1'b1, 5'd5, 1'b0, 1'b0, E_STL);
    idle("lu_release", E_RUN);
    drive("lu_rt", 1'b0, 5'd3, 5'd7, 1'b1, 5'd7, 1'b0, 1'b0, E_STL);
    drive("lu_zero", 1'b0, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, E_RUN);
    drive("lu_nomr", 1'b0, 5'd5, 5'd5, 1'b0, 5'd5, 1'b0, 1'b0, E_RUN);
    for (int i = 0; i < 12; i++) begin
      rt  = 5'($urandom_range(0, 31));
      rs  = ($urandom_range(0, 2) == 0) ? rt : 5'($urandom_range(0, 31));
      rtf = ($urandom_range(0, 3) == 0) ? rt : 5'($urandom_range(0, 31));
      mr  = 1'($urandom_range(0, 1));
      hit = mr && (rt != 5'd0) && ((rt == rs) || (rt == rtf));
      drive("lu_rand", 1'b0, rs, rtf, mr, rt, 1'b0, 1'b0, hit ? E_STL : E_RUN);
    end

    // Taken branch: flush for three cycles, states 0,1,1 then 0.
    drive("br_hit", 1'b0, 5'd1, 5'd2, 1'b0, 5'd0, 1'b1, 1'b0, E_BR);
    idle("br_fl1", E_FL);
    drive("br_fl2_lu", 1'b0, 5'd4, 5'd2, 1'b1, 5'd4, 1'b0, 1'b0, E_FL);
    idle("br_done", E_RUN);

    // Busy together with a branch, busy held four cycles.
    drive("bb_0", 1'b0, 5'd1, 5'd2, 1'b0, 5'd0, 1'b1, 1'b1, E_HOLDR);
    for (int i = 0; i < 3; i++)
      drive("bb_frz", 1'b0, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b1, E_FRZ);
    idle("bb_exit", E_FRX);
    idle("bb_fl1", E_FL);
    idle("bb_fl2", E_FL);
    idle("bb_run", E_RUN);

    // Busy in the middle of a flush keeps the remaining count.
    drive("bf_br", 1'b0, 5'd1, 5'd2, 1'b0, 5'd0, 1'b1, 1'b0, E_BR);
    drive("bf_busy", 1'b0, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b1, E_HOLDF);
    idle("bf_exit", E_FRX);
    idle("bf_fl", E_FL);
    idle("bf_run", E_RUN);

    // A second branch during FLUSH reloads the count.
    drive("rl_br", 1'b0, 5'd1, 5'd2, 1'b0, 5'd0, 1'b1, 1'b0, E_BR);
    drive("rl_br2", 1'b0, 5'd1, 5'd2, 1'b0, 5'd0, 1'b1, 1'b0, E_FL);
    idle("rl_fl1", E_FL);
    idle("rl_fl2", E_FL);
    idle("rl_run", E_RUN);

    // Busy with no branch: freeze, then return to RUN.
    drive("fz_busy", 1'b0, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b1, E_HOLDR);
    idle("fz_exit", E_FRRUN);
    idle("fz_run", E_RUN);

    // Branch and load-use in the same cycle, then reset during FLUSH.
    drive("brlu", 1'b0, 5'd6, 5'd2, 1'b1, 5'd6, 1'b1, 1'b0, E_BR);
    idle("brlu_fl", E_FL);
    drive("rst_mid", 1'b1, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, E_RST);
    idle("rst_mid_run", E_RUN);
    idle("rst_mid_run2", E_RUN);

`ifdef PIPE_PERF_CNT_EN
    for (int i = 0; i < 20; i++)
      drive("perf_stall", 1'b0, 5'd8, 5'd2, 1'b1, 5'd8, 1'b0, 1'b0, E_STL);
    idle("perf_idle0", E_RUN);
    idle("perf_idle1", E_RUN);
    @(negedge i_clk);
    #1;
    check_eq("perf_stall_cnt", {28'd0, o_data_stall_cnt}, 32'(mdl_stall));
    check_eq("perf_stall_sat", {28'd0, o_data_stall_cnt}, 32'd15);
    check_eq("perf_flush_cnt", {28'd0, o_data_flush_cnt}, 32'(mdl_flush));
`endif

    @(posedge i_clk);
    @(negedge i_clk);
    #1;
    check_eq("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
